// File: rtl/ahb2apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb2apb_pkg
// Description : Shared types and encodings for the AHB-to-APB bridge:
//               FSM state enum, HTRANS/HRESP encodings, index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb2apb_pkg;

    // Bridge sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    // AHB transfer types
    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] C_HTRANS_SEQ    = 2'b11;

    // AHB responses
    localparam logic C_HRESP_OKAY  = 1'b0;
    localparam logic C_HRESP_ERROR = 1'b1;

    // Width of the slave index field; a single slave still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : ahb2apb_pkg
`default_nettype wire

// File: rtl/ahb2apb_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb2apb_if
// Description : AHB-side and APB-side bus signals of the bridge.
//               'slave' is the bridge view (AHB slave / APB master),
//               'master' is the surrounding system view.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb2apb_if #(
    parameter int NO_OF_SLAVES = 8
);
    // AHB side
    logic                         HSELAHB;
    logic [31:0]                  HADDR;
    logic [1:0]                   HTRANS;
    logic                         HWRITE;
    logic [31:0]                  HWDATA;
    logic [31:0]                  HRDATA;
    logic                         HREADY;
    logic                         HRESP;
    // APB side
    logic [31:0]                  PADDR;
    logic [31:0]                  PWDATA;
    logic                         PWRITE;
    logic [NO_OF_SLAVES-1:0]      PSELx;
    logic                         PENABLE;
    logic [32*NO_OF_SLAVES-1:0]   PRDATA;
    logic [NO_OF_SLAVES-1:0]      PREADY;
    logic [NO_OF_SLAVES-1:0]      PSLVERR;

    modport slave (
        input  HSELAHB, HADDR, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP,
        output PADDR, PWDATA, PWRITE, PSELx, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSELAHB, HADDR, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP,
        input  PADDR, PWDATA, PWRITE, PSELx, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface : ahb2apb_if
`default_nettype wire

// File: rtl/ahb2apb_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ahb2apb_decoder
// Description : Extracts the APB slave index from the AHB address, produces
//               the one-hot select and flags indices with no slave behind them.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_decoder
    import ahb2apb_pkg::*;
#(
    parameter int NO_OF_SLAVES = 8,
    parameter int SLV_LSB      = 12,
    parameter int IDX_W        = idx_width(NO_OF_SLAVES)
) (
    input  wire logic [31:0]             i_addr,
    output logic      [IDX_W-1:0]        o_idx,
    output logic      [NO_OF_SLAVES-1:0] o_sel,
    output logic                         o_dec_err
);

    // Only the index field matters; remaining address bits are carried elsewhere
    logic w_unused_addr;
    assign w_unused_addr = ^i_addr;

    assign o_idx     = i_addr[SLV_LSB +: IDX_W];
    assign o_dec_err = (32'(o_idx) >= 32'(NO_OF_SLAVES));

    // One-hot select; an out-of-range index selects nothing
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (32'(o_idx) == 32'(i)) begin
                o_sel[i] = 1'b1;
            end
        end
    end

endmodule : ahb2apb_decoder
`default_nettype wire

// File: rtl/ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb2apb_bridge
// Description : AHB-Lite slave to APB master bridge with up to 16 APB slaves.
//               Each accepted transfer walks LATCH -> SETUP -> ACCESS, with
//               slave and decode errors reported as a two-cycle ERROR.
//               Optional PREADY watchdog: define AHB2APB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_bridge
    import ahb2apb_pkg::*;
#(
    parameter int NO_OF_SLAVES   = 8,
    parameter int SLV_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic  HCLK,
    input  wire logic  HRESETn,
    ahb2apb_if.slave   bus
);

    localparam int C_IDX_W = idx_width(NO_OF_SLAVES);

    state_t                    r_state;
    state_t                    w_state_next;

    logic [C_IDX_W-1:0]        w_dec_idx;
    logic [NO_OF_SLAVES-1:0]   w_dec_sel;
    logic                      w_dec_err;

    logic [C_IDX_W-1:0]        r_idx;
    logic [NO_OF_SLAVES-1:0]   r_sel;
    logic [31:0]               r_addr;
    logic [31:0]               r_wdata;
    logic [31:0]               r_rdata;
    logic                      r_write;

    logic                      w_hready;
    logic                      w_hresp;
    logic                      w_penable;
    logic [NO_OF_SLAVES-1:0]   w_psel;
    logic                      w_accept;
    logic                      w_pready;
    logic                      w_pslverr;
    logic                      w_tmo;
    logic [31:0]               w_prdata;

    ahb2apb_decoder #(
        .NO_OF_SLAVES (NO_OF_SLAVES),
        .SLV_LSB      (SLV_LSB),
        .IDX_W        (C_IDX_W)
    ) u_decoder (
        .i_addr    (bus.HADDR),
        .o_idx     (w_dec_idx),
        .o_sel     (w_dec_sel),
        .o_dec_err (w_dec_err)
    );

    // Only NONSEQ/SEQ start a transfer, and only while the bridge is ready
    assign w_accept  = bus.HSELAHB & w_hready &
                       ((bus.HTRANS == C_HTRANS_NONSEQ) || (bus.HTRANS == C_HTRANS_SEQ));

    // Response of the currently addressed slave
    assign w_pready  = |(bus.PREADY  & r_sel);
    assign w_pslverr = |(bus.PSLVERR & r_sel);

    // Read data of the addressed slave
    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (r_idx == C_IDX_W'(i)) begin
                w_prdata = bus.PRDATA[32*i +: 32];
            end
        end
    end

`ifdef AHB2APB_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_TMO_W-1:0] r_tmo_cnt;

    // Stalled-ACCESS counter, restarted on every SETUP entry
    always_ff @(posedge HCLK) begin
        if (!HRESETn || (r_state == LATCH)) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ACCESS) && !w_pready) begin
            r_tmo_cnt <= r_tmo_cnt + C_TMO_W'(1);
        end
    end

    // Fires on the last allowed stalled cycle so the abort lands on the next edge
    assign w_tmo = (r_state == ACCESS) && !w_pready &&
                   (r_tmo_cnt == C_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign w_tmo        = 1'b0;
`endif

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded bus outputs
    always_comb begin
        w_state_next = r_state;
        w_hready     = 1'b0;
        w_hresp      = C_HRESP_OKAY;
        w_penable    = 1'b0;
        w_psel       = '0;
        case (r_state)
            IDLE, ERR2: begin
                w_hready = 1'b1;
                w_hresp  = (r_state == ERR2) ? C_HRESP_ERROR : C_HRESP_OKAY;
                if (w_accept) begin
                    w_state_next = w_dec_err ? ERR1 : LATCH;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LATCH: begin
                w_state_next = SETUP;
            end
            SETUP: begin
                w_psel       = r_sel;
                w_state_next = ACCESS;
            end
            ACCESS: begin
                w_psel    = r_sel;
                w_penable = 1'b1;
                if (w_pready) begin
                    w_state_next = w_pslverr ? ERR1 : IDLE;
                end else if (w_tmo) begin
                    w_state_next = ERR1;
                end
            end
            ERR1: begin
                w_hresp      = C_HRESP_ERROR;
                w_state_next = ERR2;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address/control capture, write-data latch and read-data return
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.HADDR;
                r_write <= bus.HWRITE;
                r_idx   <= w_dec_idx;
                r_sel   <= w_dec_sel;
            end
            if (r_state == LATCH) begin
                r_wdata <= bus.HWDATA;
            end
            if ((r_state == ACCESS) && w_pready && !w_pslverr && !r_write) begin
                r_rdata <= w_prdata;
            end
        end
    end

    assign bus.HREADY  = w_hready;
    assign bus.HRESP   = w_hresp;
    assign bus.HRDATA  = r_rdata;
    assign bus.PADDR   = r_addr;
    assign bus.PWDATA  = r_wdata;
    assign bus.PWRITE  = r_write;
    assign bus.PSELx   = w_psel;
    assign bus.PENABLE = w_penable;

endmodule : ahb2apb_bridge
`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb2apb_bridge
// Description : Self-checking bench for ahb2apb_bridge (6 slaves). Expected
//               per-cycle bus status comes from a transfer-level timeline
//               model; APB slaves are emulated from per-transfer settings.
//               Watchdog scenario runs when AHB2APB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_bridge;

    localparam int N   = 6;
    localparam int C_W = N + 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    ahb2apb_if #(.NO_OF_SLAVES(N)) bus ();

    ahb2apb_bridge #(
        .NO_OF_SLAVES   (N),
        .SLV_LSB        (12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (bus.slave)
    );

    int          n_checks   = 0;
    int          n_errors   = 0;
    logic [31:0] exp_hrdata = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {HREADY, HRESP, PENABLE, PSELx}
    function automatic logic [C_W-1:0] status();
        return {bus.HREADY, bus.HRESP, bus.PENABLE, bus.PSELx};
    endfunction

    // Expected status k cycles after the address-phase edge
    function automatic logic [C_W-1:0] exp_status(input int k, input int idx, input int w,
                                                   input bit e, input bit derr);
        logic [N-1:0] sel;
        sel = '0;
        if (derr) begin
            return (k == 1) ? {1'b0, 1'b1, 1'b0, sel} : {1'b1, 1'b1, 1'b0, sel};
        end
        sel[idx] = 1'b1;
        if (k == 1)      return {1'b0, 1'b0, 1'b0, {N{1'b0}}};
        if (k == 2)      return {1'b0, 1'b0, 1'b0, sel};
        if (k <= 3 + w)  return {1'b0, 1'b0, 1'b1, sel};
        if (k == 4 + w)  return e ? {1'b0, 1'b1, 1'b0, {N{1'b0}}} : {1'b1, 1'b0, 1'b0, {N{1'b0}}};
        return {1'b1, 1'b1, 1'b0, {N{1'b0}}};
    endfunction

    // One AHB transfer driven in the current (HREADY=1) cycle; slave idx
    // answers after w wait states with error flag e; hang = never answer.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                        input int w, input bit e, input logic [31:0] rd, input bit hang);
        int idx;
        bit derr;
        int last;
        int lat;
        idx  = int'(addr[14:12]);
        derr = (idx >= N);
        last = derr ? 2 : (e ? 5 + w : 4 + w);
        lat  = -1;
        bus.HSELAHB = 1'b1;
        bus.HTRANS  = 2'b10;
        bus.HADDR   = addr;
        bus.HWRITE  = wr;
        bus.PREADY  = '0;
        bus.PSLVERR = '0;
        @(posedge clk); #1;
        bus.HSELAHB = 1'b0;
        bus.HTRANS  = 2'b00;
        bus.HADDR   = $urandom;
        bus.HWRITE  = 1'($urandom);
        bus.HWDATA  = wd;
        for (int k = 1; k <= last; k++) begin
            check_eq($sformatf("status a=%h k=%0d", addr, k), C_W'(status()),
                     exp_status(k, idx, w, e, derr));
            if (lat < 0 && bus.HREADY === 1'b1) lat = k;
            if (k == 2) bus.HWDATA = $urandom;
            if (!derr && k == 2) begin
                check_eq("paddr", bus.PADDR, addr);
                check_eq("pwrite", bus.PWRITE, wr);
            end
            if (!derr && wr && k == 3) check_eq("pwdata", bus.PWDATA, wd);
            if (!derr && !hang && k == 3 + w) begin
                bus.PREADY[idx]          = 1'b1;
                bus.PSLVERR[idx]         = e;
                bus.PRDATA[32*idx +: 32] = rd;
            end else begin
                bus.PREADY  = '0;
                bus.PSLVERR = '0;
            end
            if (k < last) begin
                @(posedge clk); #1;
            end
        end
        if (!derr && !e) check_eq("latency", lat, 4 + w);
        if (!derr && !wr && !e) exp_hrdata = rd;
        check_eq("hrdata", bus.HRDATA, exp_hrdata);
    endtask

    // Non-transfer cycles, including selected IDLE/BUSY, must see OKAY at once
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.HSELAHB = 1'($urandom);
            bus.HTRANS  = 2'($urandom_range(0, 1));
            bus.HADDR   = $urandom;
            @(posedge clk); #1;
            check_eq("idle status", C_W'(status()), {1'b1, 1'b0, 1'b0, {N{1'b0}}});
        end
        bus.HSELAHB = 1'b0;
        bus.HTRANS  = 2'b00;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, " status"}, C_W'(status()), {1'b1, 1'b0, 1'b0, {N{1'b0}}});
        check_eq({tag, " paddr"},  bus.PADDR,  32'h0);
        check_eq({tag, " pwdata"}, bus.PWDATA, 32'h0);
        check_eq({tag, " hrdata"}, bus.HRDATA, 32'h0);
        check_eq({tag, " pwrite"}, bus.PWRITE, 1'b0);
    endtask

    // Reset pulsed while a slave is stalling in ACCESS
    task automatic reset_mid_transfer();
        bus.HSELAHB = 1'b1;
        bus.HTRANS  = 2'b10;
        bus.HADDR   = 32'h0000_3044;
        bus.HWRITE  = 1'b1;
        bus.PREADY  = '0;
        bus.PSLVERR = '0;
        @(posedge clk); #1;
        bus.HSELAHB = 1'b0;
        bus.HTRANS  = 2'b00;
        bus.HWDATA  = 32'hA5A5_0001;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_eq("stalled access", C_W'(status()), {1'b0, 1'b0, 1'b1, 6'b001000});
        rstn = 1'b0;
        @(posedge clk); #1;
        check_reset_values("mid reset");
        exp_hrdata = '0;
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        bit          wr;
        bit          e;
        int          w;
        bus.HSELAHB = 1'b0;
        bus.HADDR   = '0;
        bus.HTRANS  = 2'b00;
        bus.HWRITE  = 1'b0;
        bus.HWDATA  = '0;
        bus.PREADY  = '0;
        bus.PSLVERR = '0;
        for (int i = 0; i < N; i++) bus.PRDATA[32*i +: 32] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rstn = 1'b1;
        idle_cycles(2);

        // Directed: zero-wait write to slave 2
        xfer(32'h0000_2010, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 1'b0);
        // Directed: read from slave 5 with three wait states
        xfer(32'h0000_5008, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0);
        // Directed: slave error from slave 1, then a back-to-back read from ERR2
        xfer(32'h0000_1000, 1'b1, 32'h0BAD_0BAD, 0, 1'b1, 32'h0, 1'b0);
        xfer(32'h0000_0004, 1'b0, 32'h0, 1, 1'b0, 32'h5555_AAAA, 1'b0);
        // Directed: decode error (index 7 with six slaves)
        xfer(32'h0000_7000, 1'b1, 32'h1111_2222, 0, 1'b0, 32'h0, 1'b0);
        idle_cycles(1);
`ifdef AHB2APB_TIMEOUT_EN
        // Slave 4 never answers: sixteen ACCESS cycles, then ERROR
        xfer(32'h0000_4020, 1'b0, 32'h0, 15, 1'b1, 32'h0, 1'b1);
        idle_cycles(1);
`endif
        reset_mid_transfer();
        idle_cycles(1);

        // Randomized transfers, mostly back-to-back
        for (int t = 0; t < 40; t++) begin
            a        = $urandom;
            a[14:12] = 3'($urandom_range(0, 7));
            wr       = 1'($urandom);
            w        = $urandom_range(0, 3);
            e        = wr && ($urandom_range(0, 4) == 0);
            xfer(a, wr, $urandom, w, e, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ahb2apb_bridge
`default_nettype wire

// File: doc/ahb2apb_bridge.md
AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

Interface
REQ-001 Parameters SHALL be:
  - NO_OF_SLAVES, default 8, number of APB slaves (legal 1..16).
  - SLV_LSB, default 12, lowest HADDR bit of the slave index field.
  - TIMEOUT_CYCLES, default 16, PREADY wait limit (used only when the timeout is compiled in).
REQ-002 Ports SHALL be:
  - HCLK  in  1  sole clock.
  - HRESETn  in  1  synchronous active-low reset.
  - HSELAHB  in  1  bridge select.
  - HADDR  in  32  AHB address.
  - HTRANS  in  2  transfer type.
  - HWRITE  in  1  AHB direction.
  - HWDATA  in  32  AHB write data.
  - HRDATA  out  32  AHB read data.
  - HREADY  out  1  transfer done.
  - HRESP  out  1  error response.
  - PADDR  out  32  APB address.
  - PWDATA  out  32  APB write data.
  - PWRITE  out  1  APB direction.
  - PSELx  out  NO_OF_SLAVES  one-hot slave select.
  - PENABLE  out  1  APB access phase.
  - PRDATA  in  32*NO_OF_SLAVES  packed read data, slave i at bits [32i+31:32i].
  - PREADY  in  NO_OF_SLAVES  per-slave ready.
  - PSLVERR  in  NO_OF_SLAVES  per-slave error.
REQ-003 The design SHALL use one clock, HCLK; reset HRESETn SHALL be synchronous and active-low.

Function
REQ-004 Transfer acceptance SHALL occur when HSELAHB=1, HTRANS[1]=1 and HREADY=1 at a rising edge; the bridge SHALL then capture HADDR and HWRITE. IDLE/BUSY transfers SHALL get a zero-wait OKAY response.
REQ-005 Slave index SHALL be HADDR[SLV_LSB +: IDX_W], with IDX_W=max(1,clog2(NO_OF_SLAVES)); an index >= NO_OF_SLAVES is a decode error.
REQ-006 FSM states SHALL be IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
REQ-007 FSM transitions SHALL be:
  - IDLE/ERR2 -> LATCH on a valid decoded transfer.
  - IDLE/ERR2 -> ERR1 on a decode error.
  - IDLE/ERR2 -> IDLE otherwise.
  - LATCH -> SETUP.
  - SETUP -> ACCESS.
  - ACCESS -> IDLE when PREADY[idx]=1 and PSLVERR[idx]=0.
  - ACCESS -> ERR1 when PREADY[idx]=1 and PSLVERR[idx]=1.
  - ACCESS -> ACCESS while PREADY[idx]=0.
  - ERR1 -> ERR2.
REQ-008 The LATCH state SHALL register HWDATA into PWDATA; PWDATA, PADDR and PWRITE SHALL remain stable through SETUP and ACCESS.
REQ-009 PSELx[idx] SHALL be 1 in SETUP and ACCESS and 0 elsewhere; PENABLE SHALL be 1 only in ACCESS; PSELx SHALL never have more than one bit set.
REQ-010 HREADY SHALL be 0 in LATCH, SETUP, ACCESS and ERR1, and 1 in IDLE and ERR2; HRESP SHALL be 1 only in ERR1 and ERR2.
REQ-011 On a read completing in ACCESS, HRDATA SHALL register PRDATA[idx] and hold it until the next read completes.
REQ-012 Latency: for a zero-wait APB slave, HREADY SHALL return to 1 exactly 4 cycles after the address-phase edge; each PREADY=0 cycle SHALL add one cycle.
REQ-013 Back-to-back transfers: a transfer presented in the cycle HREADY=1 (IDLE or ERR2) SHALL be accepted with no bubble.
REQ-014 PADDR SHALL equal the full captured HADDR.

Reset
REQ-015 While HRESETn=0 at an edge, the bridge SHALL reset to:
  - state = IDLE
  - HREADY = 1, HRESP = 0
  - HRDATA, PADDR, PWDATA = 0
  - PWRITE, PENABLE = 0, PSELx = 0
  - timeout counter = 0
REQ-016 Reset asserted mid-transfer SHALL abandon the transfer; no APB signal SHALL remain asserted after that edge.

Configuration
REQ-017 The PREADY watchdog SHALL be compiled in by macro AHB2APB_TIMEOUT_EN.
  - Defined: a counter SHALL count ACCESS cycles with PREADY[idx]=0. When it reaches TIMEOUT_CYCLES, the bridge SHALL deassert PSELx and PENABLE at the next edge and enter ERR1. The counter SHALL clear on every SETUP entry.
  - Undefined: no counter logic SHALL exist; ACCESS SHALL wait indefinitely.

Structure
REQ-018 Package ahb2apb_pkg SHALL hold the FSM state enum, the HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3) and the HRESP encodings (OKAY=0, ERROR=1).
REQ-019 Sub-module ahb2apb_decoder SHALL compute the index, the one-hot select and the decode-error flag from HADDR.

Verification
REQ-020 Write: HADDR=0x0000_2010, HWDATA=0xCAFE_F00D, slave 2 zero-wait -> PSELx=8'b0000_0100, PWDATA=0xCAFE_F00D, HREADY high 4 cycles after the address phase, HRESP=0.
REQ-021 Read: slave 5 returns 0x1234_5678 after 3 PREADY=0 cycles -> HRDATA=0x1234_5678, HREADY high 7 cycles after the address phase.
REQ-022 Slave error: PSLVERR[1]=1 at completion -> ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), then OKAY.
REQ-023 Decode error: NO_OF_SLAVES=6, HADDR=0x0000_7000 -> PSELx stays 0 and a two-cycle ERROR response is returned.
REQ-024 Timeout (macro defined, TIMEOUT_CYCLES=16): PREADY stuck at 0 -> PSELx drops after 16 ACCESS cycles and an ERROR response follows. Reset pulsed during ACCESS -> all outputs at reset values on the next cycle.
